// File: rtl/axi2iob.sv
// axi2iob: AXI-4 slave to native (IOb) master bridge, one burst at a time replayed as single-word native requests.
// Ports: clk, rst (async, active-high); s_axi_aw*/w*/b*/ar*/r* AXI-4 slave channels
// (lock/cache/prot/qos ignored); m_valid/m_addr/m_wdata/m_wstrb/m_rdata/m_ready native master port.
module axi2iob #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int AXI_ID_W = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AXI_ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic [1:0]            s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic [3:0]            s_axi_awqos,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_W-1:0]     s_axi_wdata,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [AXI_ID_W-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [AXI_ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic [1:0]            s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arqos,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [AXI_ID_W-1:0]   s_axi_rid,
  output logic [DATA_W-1:0]     s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  m_valid,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ready
);
  localparam int NB = DATA_W / 8;
  localparam logic [2:0] SZ = 3'($clog2(NB));
  localparam logic [ADDR_W-1:0] LOW = ADDR_W'(NB - 1);
  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;
  state_t state, state_nx;
  logic [AXI_ID_W-1:0] id;
  logic [7:0] len, cnt;
  logic fixed, err, last, m_hs, w_hs, r_hs;
  logic [ADDR_W-1:0] addr_nx;
  logic unused;
  assign unused = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                    s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};
  assign last = cnt == len;
  assign m_hs = m_valid & m_ready;
  assign w_hs = s_axi_wready & s_axi_wvalid;
  assign r_hs = s_axi_rvalid & s_axi_rready;
  assign addr_nx = fixed ? m_addr : m_addr + ADDR_W'(NB);
  assign s_axi_bid = id;
  assign s_axi_rid = id;
  assign s_axi_bresp = {err, 1'b0};
  assign s_axi_rresp = {err, 1'b0};
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = s_axi_awready ? WR_DATA : s_axi_arready ? RD_DATA : IDLE;
      WR_DATA: state_nx = m_hs & last ? WR_RESP : WR_DATA;
      WR_RESP: state_nx = s_axi_bready ? IDLE : WR_RESP;
      RD_DATA: state_nx = r_hs & s_axi_rlast ? IDLE : RD_DATA;
      default: state_nx = IDLE;
    endcase
  end
  // Writes take priority when AW and AR arrive together; nothing is accepted while reset is held.
  always_comb begin
    s_axi_awready = ~rst & (state == IDLE) & s_axi_awvalid;
    s_axi_arready = ~rst & (state == IDLE) & s_axi_arvalid & ~s_axi_awvalid;
    s_axi_wready  = (state == WR_DATA) & ~m_valid;
    s_axi_bvalid  = state == WR_RESP;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      id <= '0;
      len <= '0;
      cnt <= '0;
      fixed <= 1'b0;
      err <= 1'b0;
      m_valid <= 1'b0;
      m_addr <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
      s_axi_rvalid <= 1'b0;
      s_axi_rlast <= 1'b0;
      s_axi_rdata <= '0;
    end else begin
      if (s_axi_awready | s_axi_arready) begin
        id <= s_axi_awready ? s_axi_awid : s_axi_arid;
        m_addr <= (s_axi_awready ? s_axi_awaddr : s_axi_araddr) & ~LOW;
        len <= s_axi_awready ? s_axi_awlen : s_axi_arlen;
        fixed <= (s_axi_awready ? s_axi_awburst : s_axi_arburst) == 2'b00;
        // WRAP and reserved bursts run as INCR but are flagged as SLVERR.
        err <= s_axi_awready ? (s_axi_awsize != SZ) | s_axi_awburst[1]
                             : (s_axi_arsize != SZ) | s_axi_arburst[1];
        cnt <= '0;
        m_valid <= s_axi_arready;
        m_wstrb <= '0;
      end
      // The burst end follows the beat count; a misplaced wlast only flags the error.
      if (w_hs) begin
        m_valid <= 1'b1;
        m_wdata <= s_axi_wdata;
        m_wstrb <= s_axi_wstrb;
        err <= err | (s_axi_wlast != last);
      end
      if (m_hs) begin
        m_valid <= 1'b0;
        if (state == WR_DATA) begin
          m_addr <= addr_nx;
          cnt <= cnt + 8'd1;
        end else begin
          s_axi_rvalid <= 1'b1;
          s_axi_rdata <= m_rdata;
          s_axi_rlast <= last;
        end
      end
      if (r_hs) begin
        s_axi_rvalid <= 1'b0;
        s_axi_rlast <= 1'b0;
        if (!s_axi_rlast) begin
          m_addr <= addr_nx;
          cnt <= cnt + 8'd1;
          m_valid <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_axi2iob.sv
// tb_axi2iob: randomized and directed checks of axi2iob against a transaction-level model.
module tb_axi2iob;
  logic clk = 0, rst = 1;
  logic [1:0] s_axi_awid = 0, s_axi_arid = 0, s_axi_bid, s_axi_rid, s_axi_bresp, s_axi_rresp;
  logic [15:0] s_axi_awaddr = 0, s_axi_araddr = 0, m_addr;
  logic [7:0] s_axi_awlen = 0, s_axi_arlen = 0;
  logic [2:0] s_axi_awsize = 0, s_axi_arsize = 0;
  logic [1:0] s_axi_awburst = 0, s_axi_arburst = 0;
  logic s_axi_awvalid = 0, s_axi_awready, s_axi_wlast = 0, s_axi_wvalid = 0, s_axi_wready;
  logic s_axi_bvalid, s_axi_bready = 0, s_axi_arvalid = 0, s_axi_arready;
  logic s_axi_rlast, s_axi_rvalid, s_axi_rready = 0, m_valid, m_ready = 0;
  logic [31:0] s_axi_wdata = 0, s_axi_rdata, m_wdata, m_rdata = 0;
  logic [3:0] s_axi_wstrb = 0, m_wstrb;

  axi2iob #(.ADDR_W(16), .DATA_W(32), .AXI_ID_W(2)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(2'b0),
    .s_axi_awcache(4'b0), .s_axi_awprot(3'b0), .s_axi_awqos(4'b0),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(2'b0),
    .s_axi_arcache(4'b0), .s_axi_arprot(3'b0), .s_axi_arqos(4'b0),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] a; logic [31:0] d; logic [3:0] s; bit wr; bit last; } nat_t;
  typedef struct { logic [31:0] d; logic [1:0] resp; bit last; logic [1:0] id; } r_t;
  typedef struct { logic [1:0] id; logic [1:0] resp; } b_t;

  int cmp = 0, fails = 0, dly = -1, rdy_fix = -1;
  nat_t exp_nat[$];
  r_t exp_r[$];
  b_t exp_b[$];
  logic [31:0] rmem[1024], mmem[1024];
  logic [31:0] wd[256];
  logic [3:0] ws[256];
  logic wl[256];
  logic [15:0] obs_addr[$];
  logic [31:0] obs_wd[$], obs_rd[$];
  logic [1:0] obs_rresp[$];
  logic obs_rlast[$];
  int ev_log[$];
  logic [1:0] last_bid, last_bresp;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  endtask

  function automatic logic sig(input int ch);
    case (ch)
      0: return s_axi_awready;
      1: return s_axi_wready;
      2: return s_axi_arready;
      3: return s_axi_bvalid;
      default: return s_axi_rvalid;
    endcase
  endfunction

  task automatic wait_sig(input int ch, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!sig(ch) && n < 2000);
    if (!sig(ch)) begin
      cmp++; fails++;
      $display("FAIL timeout waiting for %s", nm);
      summary();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    obs_addr.delete(); obs_wd.delete(); obs_rd.delete();
    obs_rresp.delete(); obs_rlast.delete(); ev_log.delete();
  endtask

  // Transaction model: expected native beats, responses and memory contents.
  task automatic model_write(input logic [1:0] id, input logic [15:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst, input int bad_last, input bit gen);
    logic [15:0] a = addr & 16'hFFFC;
    bit err = (size != 3'd2) || burst[1];
    for (int i = 0; i <= len; i++) begin
      if (gen) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
      wl[i] = (i == len) != (i == bad_last);
      if (wl[i] != (i == len)) err = 1;
      exp_nat.push_back('{a, wd[i], ws[i], 1'b1, i == len});
      for (int b = 0; b < 4; b++) if (ws[i][b]) mmem[a[11:2]][8*b+:8] = wd[i][8*b+:8];
      if (burst != 2'b00) a = a + 16'd4;
    end
    exp_b.push_back('{id, err ? 2'b10 : 2'b00});
  endtask

  task automatic model_read(input logic [1:0] id, input logic [15:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [15:0] a = addr & 16'hFFFC;
    bit err = (size != 3'd2) || burst[1];
    for (int i = 0; i <= len; i++) begin
      exp_nat.push_back('{a, 32'h0, 4'h0, 1'b0, i == len});
      exp_r.push_back('{mmem[a[11:2]], err ? 2'b10 : 2'b00, i == len, id});
      if (burst != 2'b00) a = a + 16'd4;
    end
  endtask

  task automatic drive_write(input logic [1:0] id, input logic [15:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst);
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1;
    wait_sig(0, "awready");
    @(posedge clk); #1 s_axi_awvalid = 0;
    for (int i = 0; i <= len; i++) begin
      idle($urandom_range(0, 2));
      s_axi_wdata = wd[i]; s_axi_wstrb = ws[i]; s_axi_wlast = wl[i]; s_axi_wvalid = 1;
      wait_sig(1, "wready");
      @(posedge clk); #1 s_axi_wvalid = 0; s_axi_wlast = 0;
    end
    idle($urandom_range(0, 3));
    s_axi_bready = 1;
    wait_sig(3, "bvalid");
    @(posedge clk); #1 s_axi_bready = 0;
  endtask

  task automatic drive_read(input logic [1:0] id, input logic [15:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int hold_beat, input int hold_n);
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1;
    wait_sig(2, "arready");
    @(posedge clk); #1 s_axi_arvalid = 0;
    for (int i = 0; i <= len; i++) begin
      if (i == hold_beat) begin
        wait_sig(4, "rvalid");
        idle(hold_n);
      end else idle($urandom_range(0, 2));
      s_axi_rready = 1;
      wait_sig(4, "rvalid");
      @(posedge clk); #1 s_axi_rready = 0;
    end
  endtask

  task automatic check_zero(input string nm);
    chk(nm, {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast,
             m_valid, s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid, s_axi_rdata}, 0);
    chk({nm, "_native"}, {m_addr, m_wdata, m_wstrb}, 0);
  endtask

  // Native memory responder with random or fixed acknowledge latency.
  initial forever begin
    @(posedge clk); #1;
    m_ready = 0;
    if (!rst && m_valid) begin
      if (dly < 0) dly = rdy_fix >= 0 ? rdy_fix : $urandom_range(0, 3);
      if (dly == 0) begin
        m_ready = 1;
        m_rdata = rmem[m_addr[11:2]];
        for (int b = 0; b < 4; b++) if (m_wstrb[b]) rmem[m_addr[11:2]][8*b+:8] = m_wdata[8*b+:8];
        dly = -1;
      end else dly--;
    end else dly = -1;
  end

  // Per-cycle compare process: payloads against the model, latencies and stability against the protocol rules.
  bit p_aw, p_ar, p_w, p_b, p_nw, p_nwl, p_nr, p_r, p_rl, p_mp, p_rp, p_bp;
  logic [51:0] snap_m;
  logic [36:0] snap_r;
  logic [3:0] snap_b;
  nat_t en;
  r_t er;
  b_t eb;
  always @(negedge clk) begin
    if (rst) {p_aw, p_ar, p_w, p_b, p_nw, p_nwl, p_nr, p_r, p_rl, p_mp, p_rp, p_bp} = '0;
    else begin
      if (p_aw) chk("wready_after_aw", s_axi_wready, 1);
      if (p_ar) chk("mvalid_after_ar", m_valid, 1);
      if (p_w) chk("mvalid_wready_after_w", {m_valid, s_axi_wready}, 2'b10);
      if (p_nw && p_nwl) chk("bvalid_after_last_write", s_axi_bvalid, 1);
      if (p_nw && !p_nwl) chk("wready_after_write_beat", {m_valid, s_axi_wready}, 2'b01);
      if (p_nr) chk("rvalid_after_read_beat", {m_valid, s_axi_rvalid}, 2'b01);
      if (p_r && !p_rl) chk("mvalid_after_r", m_valid, 1);
      if (p_r && p_rl) chk("idle_after_rlast", {m_valid, s_axi_rvalid, s_axi_awready}, {2'b00, s_axi_awvalid});
      if (p_b) chk("bvalid_drop", s_axi_bvalid, 0);
      if (p_mp) chk("m_hold", {m_valid, m_addr, m_wdata, m_wstrb}, {1'b1, snap_m});
      if (p_rp) chk("r_hold", {s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid}, {1'b1, snap_r});
      if (p_bp) chk("b_hold", {s_axi_bvalid, s_axi_bresp, s_axi_bid}, {1'b1, snap_b});
      if (s_axi_awvalid) chk("write_priority", s_axi_arready, 0);
      {p_nw, p_nr, p_nwl} = '0;
      if (m_valid && m_ready) begin
        if (exp_nat.size() == 0) begin
          cmp++; fails++;
          $display("FAIL native_unexpected: got addr %0h expected no request", m_addr);
        end else begin
          en = exp_nat.pop_front();
          chk("nat_addr", m_addr, en.a);
          chk("nat_wstrb", m_wstrb, en.s);
          if (en.wr) chk("nat_wdata", m_wdata, en.d);
          p_nw = en.wr; p_nr = !en.wr; p_nwl = en.last;
        end
        obs_addr.push_back(m_addr);
        obs_wd.push_back(m_wdata);
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (exp_r.size() == 0) begin
          cmp++; fails++;
          $display("FAIL r_unexpected: got data %0h expected no beat", s_axi_rdata);
        end else begin
          er = exp_r.pop_front();
          chk("r_beat", {s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid}, {er.d, er.resp, er.last, er.id});
        end
        obs_rd.push_back(s_axi_rdata);
        obs_rresp.push_back(s_axi_rresp);
        obs_rlast.push_back(s_axi_rlast);
        ev_log.push_back(2);
      end
      if (s_axi_bvalid && s_axi_bready) begin
        if (exp_b.size() == 0) begin
          cmp++; fails++;
          $display("FAIL b_unexpected: got resp %0h expected no response", s_axi_bresp);
        end else begin
          eb = exp_b.pop_front();
          chk("b_resp", {s_axi_bid, s_axi_bresp}, {eb.id, eb.resp});
        end
        last_bid = s_axi_bid;
        last_bresp = s_axi_bresp;
        ev_log.push_back(1);
      end
      p_aw = s_axi_awvalid & s_axi_awready;
      p_ar = s_axi_arvalid & s_axi_arready;
      p_w = s_axi_wvalid & s_axi_wready;
      p_b = s_axi_bvalid & s_axi_bready;
      p_r = s_axi_rvalid & s_axi_rready;
      p_rl = s_axi_rlast;
      p_mp = m_valid & ~m_ready;
      p_rp = s_axi_rvalid & ~s_axi_rready;
      p_bp = s_axi_bvalid & ~s_axi_bready;
      snap_m = {m_addr, m_wdata, m_wstrb};
      snap_r = {s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid};
      snap_b = {s_axi_bresp, s_axi_bid};
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      rmem[i] = 32'hC0DE_0000 ^ (i * 32'h0001_9E37);
      mmem[i] = rmem[i];
    end
    repeat (3) @(posedge clk);
    #1 check_zero("reset_state");
    rst = 0;
    idle(2);

    // single write
    clear_logs();
    rdy_fix = 0;
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    model_write(2'd1, 16'h0104, 0, 3'd2, 2'b01, -1, 0);
    drive_write(2'd1, 16'h0104, 0, 3'd2, 2'b01);
    idle(2);
    chk("t1_beats", obs_addr.size(), 1);
    chk("t1_addr", obs_addr[0], 16'h0104);
    chk("t1_wdata", obs_wd[0], 32'hDEADBEEF);
    chk("t1_b", {last_bid, last_bresp}, 4'b0100);
    rdy_fix = -1;

    // INCR read burst of preset data
    for (int i = 0; i < 4; i++) begin rmem[128 + i] = 32'h10 + i; mmem[128 + i] = 32'h10 + i; end
    clear_logs();
    model_read(2'd2, 16'h0200, 3, 3'd2, 2'b01);
    drive_read(2'd2, 16'h0200, 3, 3'd2, 2'b01, -1, 0);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", obs_addr[i], 16'h0200 + 16'(4 * i));
      chk("t2_data", obs_rd[i], 32'h10 + i);
      chk("t2_last_resp", {obs_rlast[i], obs_rresp[i]}, {i == 3, 2'b00});
    end

    // backpressure on R and native ready
    clear_logs();
    rdy_fix = 3;
    model_read(2'd3, 16'h0200, 3, 3'd2, 2'b01);
    drive_read(2'd3, 16'h0200, 3, 3'd2, 2'b01, 1, 5);
    idle(2);
    for (int i = 0; i < 4; i++) chk("t3_data", obs_rd[i], 32'h10 + i);
    rdy_fix = -1;

    // simultaneous AW and AR
    clear_logs();
    model_write(2'd0, 16'h0500, 1, 3'd2, 2'b01, -1, 1);
    model_read(2'd1, 16'h0500, 1, 3'd2, 2'b01);
    fork
      drive_write(2'd0, 16'h0500, 1, 3'd2, 2'b01);
      drive_read(2'd1, 16'h0500, 1, 3'd2, 2'b01, -1, 0);
      begin @(negedge clk); chk("t4_arbit", {s_axi_awready, s_axi_arready}, 2'b10); end
    join
    idle(2);
    chk("t4_events", ev_log.size(), 3);
    chk("t4_order", ev_log[0], 1);

    // FIXED write
    clear_logs();
    model_write(2'd1, 16'h0040, 3, 3'd2, 2'b00, -1, 1);
    drive_write(2'd1, 16'h0040, 3, 3'd2, 2'b00);
    idle(2);
    for (int i = 0; i < 4; i++) chk("t5_fixed_addr", obs_addr[i], 16'h0040);
    chk("t5_bresp", last_bresp, 2'b00);

    // WRAP read
    clear_logs();
    model_read(2'd2, 16'h0080, 3, 3'd2, 2'b10);
    drive_read(2'd2, 16'h0080, 3, 3'd2, 2'b10, -1, 0);
    idle(2);
    for (int i = 0; i < 4; i++) chk("t6_wrap_resp", obs_rresp[i], 2'b10);

    // bad size
    clear_logs();
    model_write(2'd0, 16'h0060, 0, 3'd1, 2'b01, -1, 1);
    drive_write(2'd0, 16'h0060, 0, 3'd1, 2'b01);
    idle(2);
    chk("t7_size_bresp", last_bresp, 2'b10);

    // early wlast
    clear_logs();
    model_write(2'd3, 16'h0070, 3, 3'd2, 2'b01, 1, 1);
    drive_write(2'd3, 16'h0070, 3, 3'd2, 2'b01);
    idle(2);
    chk("t8_beats", obs_addr.size(), 4);
    chk("t8_bresp", last_bresp, 2'b10);

    // INCR wrapping past the top of the address space
    clear_logs();
    model_write(2'd1, 16'hFFF8, 3, 3'd2, 2'b01, -1, 1);
    drive_write(2'd1, 16'hFFF8, 3, 3'd2, 2'b01);
    idle(2);
    chk("t9_wrap_addr", obs_addr[2], 16'h0000);

    // reset during beat 2 of a write; the data rewritten equals memory so the model stays in step
    clear_logs();
    rdy_fix = 3;
    for (int i = 0; i < 2; i++) begin
      wd[i] = mmem[192 + i]; ws[i] = 4'hF;
      exp_nat.push_back('{16'h0300 + 16'(4 * i), wd[i], 4'hF, 1'b1, 1'b0});
    end
    s_axi_awid = 2'd1; s_axi_awaddr = 16'h0300; s_axi_awlen = 8'd3;
    s_axi_awsize = 3'd2; s_axi_awburst = 2'b01; s_axi_awvalid = 1;
    wait_sig(0, "awready");
    @(posedge clk); #1 s_axi_awvalid = 0;
    for (int i = 0; i < 2; i++) begin
      s_axi_wdata = wd[i]; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
      wait_sig(1, "wready");
      @(posedge clk); #1 s_axi_wvalid = 0;
    end
    #1 rst = 1;
    #1 check_zero("mid_burst_reset");
    exp_nat.delete(); exp_r.delete(); exp_b.delete();
    @(posedge clk); #2 rst = 0;
    idle(1);
    rdy_fix = -1;
    model_write(2'd2, 16'h0310, 1, 3'd2, 2'b01, -1, 1);
    drive_write(2'd2, 16'h0310, 1, 3'd2, 2'b01);
    idle(2);
    chk("t10_after_reset_b", {last_bid, last_bresp}, 4'b1000);

    // randomized traffic
    repeat (40) begin
      logic [1:0] id = 2'($urandom_range(0, 3));
      logic [15:0] addr = 16'($urandom);
      int len = $urandom_range(0, 9) == 0 ? 15 : $urandom_range(0, 7);
      int r = $urandom_range(0, 9);
      logic [1:0] burst = r < 6 ? 2'b01 : r < 8 ? 2'b00 : r == 8 ? 2'b10 : 2'b11;
      logic [2:0] size = $urandom_range(0, 7) == 0 ? 3'd1 : 3'd2;
      if ($urandom_range(0, 1) == 1) begin
        int bad = $urandom_range(0, 7) == 0 ? $urandom_range(0, len) : -1;
        model_write(id, addr, len, size, burst, bad, 1);
        drive_write(id, addr, len, size, burst);
      end else begin
        model_read(id, addr, len, size, burst);
        drive_read(id, addr, len, size, burst, -1, 0);
      end
    end
    idle(5);
    chk("left_native", exp_nat.size(), 0);
    chk("left_r", exp_r.size(), 0);
    chk("left_b", exp_b.size(), 0);
    summary();
  end
endmodule
